// File: rtl/dmem_responder.sv
// Data-memory responder: one 64-bit little-endian read/write at a time, fixed access latency.
// Optional: define DMEM_ALIGN_CHECK_EN to also fault addresses with addr[2:0] != 0.
module dmem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and response payload stays stable
  // while rsp_valid_o is high and rsp_ready_i is low.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  logic [7:0]    mem [MEM_BYTES];
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          run_q;
  logic          lat_we;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          commit;
  logic          c_we;
  logic [63:0]   c_addr;
  logic [63:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          c_err;
  logic [63:0]   c_rdata;

  // run_q keeps the request port closed until the first edge after reset release.
  assign req_ready_o = (state == IDLE) && run_q;
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = err_q;
  assign dbg_state_o = state;

  assign accept = req_valid_i && req_ready_o;
  assign commit = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));

  // With LATENCY=1 the commit happens on the accept edge itself, so use the live request.
  assign c_we    = (state == IDLE) ? req_we_i    : lat_we;
  assign c_addr  = (state == IDLE) ? req_addr_i  : lat_addr;
  assign c_wdata = (state == IDLE) ? req_wdata_i : lat_wdata;
  assign c_idx   = c_addr[AW-1:0];

  // Bounds test against a constant so addresses near 2^64 cannot wrap.
  always_comb begin
    c_err = (c_addr > MAX_ADDR);
`ifdef DMEM_ALIGN_CHECK_EN
    c_err = c_err || (c_addr[2:0] != 3'd0);
`endif
  end

  always_comb begin
    c_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      c_rdata[8*i +: 8] = mem[c_idx + AW'(i)];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      run_q     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (commit) begin
        state   <= RESP;
        cnt     <= 4'd0;
        err_q   <= c_err;
        rdata_q <= (c_we || c_err) ? 64'd0 : c_rdata;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              lat_we    <= req_we_i;
              lat_addr  <= req_addr_i;
              lat_wdata <= req_wdata_i;
              state     <= WAIT;
              cnt       <= 4'(LATENCY - 1);
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          RESP: begin
            if (rsp_ready_i) begin
              state   <= IDLE;
              rdata_q <= '0;
              err_q   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Array is deliberately not reset; a write lands only on its commit edge.
  always_ff @(posedge clk_i) begin
    if (commit && c_we && !c_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[c_idx + AW'(i)] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule
